pe_pad_sequencer: RTL
=====================

Name: pe_pad_sequencer

Overview:
- Per-PE scratchpad controller: sequences ifmap, weight and psum pad accesses for one row-stationary tile (Tw output pixels, each Pm filters x Pch channels x R taps).
- Meters ifmap words into the circular ipad.
- Issues one MAC read-set per cycle.
- Returns psum write-backs after a fixed datapath latency.
- Sits between the PE config/instruction logic and the pad RFs plus the MAC datapath inside each PE.

Parameters:
- IPADSIZE, 12, ipad depth in words
- WPADSIZE, 48, wpad depth in words
- PPADSIZE, 64, ppad depth in words
- IPADADDRWD, $clog2(IPADSIZE), ipad address width
- WPADADDRWD, $clog2(WPADSIZE), wpad address width
- PPADADDRWD, $clog2(PPADSIZE), ppad address width
- PIPE, 2, cycles from pad read issue to psum write-back (must be >=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin tile; sampled only in IDLE
- stall  in  1  freezes all counters, state and the write-back pipe
- cfg_pch  in  4  channels per pass
- cfg_pm  in  5  filters per pass
- cfg_r  in  4  filter width
- cfg_tw  in  7  output pixels in tile
- cfg_upix  in  IPADADDRWD+1  new ifmap words per output pixel (U*Pch)
- in_valid  in  1  ifmap word present
- in_ready  out  1  ipad slot free
- ip_write  out  1  =in_valid&in_ready
- ip_waddr  out  IPADADDRWD  ipad write pointer
- ip_read  out  1  ipad read strobe
- ip_raddr  out  IPADADDRWD  ipad read address
- wp_read  out  1  wpad read strobe
- wp_raddr  out  WPADADDRWD  wpad read address
- pp_read  out  1  ppad read strobe (accumulate)
- pp_raddr  out  PPADADDRWD  ppad read address
- fst_acc  out  1  first accumulation of this psum; datapath initialises it to 0
- pp_write  out  1  psum write-back strobe
- pp_waddr  out  PPADADDRWD  psum write-back address
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at tile end
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: state IDLE; all outputs 0; counters, wptr, base and avail cleared. A reset mid-tile aborts immediately; the write-back pipe is flushed with no writes.
- States: IDLE, WAIT, RUN, DRAIN.
- IDLE + start: latch cfg and compute isz=pch*r.
  - Reject and pulse cfg_err next cycle, remaining in IDLE, if any of: a field is 0; isz>IPADSIZE; isz*pm>WPADSIZE; pm*tw>PPADSIZE; upix==0; upix>isz.
  - Otherwise go to WAIT.
- Ifmap metering (all non-IDLE states):
  - in_ready = busy & (avail<IPADSIZE).
  - Each ip_write: ip_waddr=wptr, then wptr wraps mod IPADSIZE and avail+1.
- WAIT -> RUN when avail>=isz. Checked while not stalled.
- RUN issues one MAC per unstalled cycle:
  - Loop order: m innermost, then c, then r.
  - ip_read=wp_read=1.
  - ip_raddr=(base+r*pch+c) mod IPADSIZE.
  - wp_raddr=(r*pch+c)*pm+m, kept as a running counter that restarts at 0 per pixel.
  - pp_raddr=pbase+m.
  - fst_acc=(r==0&&c==0); pp_read=!fst_acc.
- Last MAC of a pixel:
  - base=(base+upix) mod IPADSIZE; pbase+=pm; x+=1.
  - avail-=upix. A simultaneous ip_write gives avail=avail+1-upix.
  - If x was tw-1, go to DRAIN; else go to WAIT. WAIT passes straight through next cycle if data is already present (one bubble per pixel).
- Write-back: the issued pp_raddr plus a valid bit pass through a PIPE-deep shift register, which advances only when !stall. Its output drives pp_write/pp_waddr, so every issued MAC produces exactly one write.
- DRAIN: after PIPE unstalled cycles, pulse done and go to IDLE. On the same edge clear avail, wptr, base and pbase; leftover ifmap words are discarded.
- stall: all strobes (ip_read, wp_read, pp_read, pp_write, ip_write) are forced 0. Addresses hold. in_ready=0.
- start outside IDLE is ignored.

Test Plan:
- pch=2,r=3,pm=2,tw=2,upix=2; stream 8 words, no stall.
  - ipad writes at addresses 0..7.
  - Pixel0: 12 issues; ip_raddr 0,0,1,1,..,5,5; wp_raddr 0..11; pp_raddr alternating 0,1; fst_acc only on the first 2 issues.
  - Pixel1: ip base 2, pp_raddr 2,3.
  - 24 pp_writes, each PIPE cycles after its issue; done once; busy drops the same cycle.
- Same config, in_valid held high: in_ready deasserts at avail=12. ipad wrap: waddr 11 is followed by 0, and ip_raddr wraps modulo 12.
- Assert stall for 3 cycles mid-pixel: strobes go 0 and addresses freeze; sequence resumes identically and total write count is unchanged.
- Starve input with only 5 words: stays in WAIT with no reads. The 6th word enters RUN the following cycle.
- start with pch=4,r=4 (isz=16>12), then pm=0: cfg_err pulses, busy stays 0, no strobes.
- Assert rst mid-RUN: all outputs 0 the next cycle; no pp_write after reset; a new start runs cleanly.

Source files
------------

// File: rtl/pe_pad_sequencer.sv
// Per-PE scratchpad sequencer: meters ifmap words into the circular ipad, issues one
// MAC read-set per cycle for a row-stationary tile, and returns psum write-backs PIPE cycles later.
module pe_pad_sequencer #(
  parameter int IPADSIZE   = 12,
  parameter int WPADSIZE   = 48,
  parameter int PPADSIZE   = 64,
  parameter int IPADADDRWD = $clog2(IPADSIZE),
  parameter int WPADADDRWD = $clog2(WPADSIZE),
  parameter int PPADADDRWD = $clog2(PPADSIZE),
  parameter int PIPE       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic [3:0]            cfg_pch,
  input  logic [4:0]            cfg_pm,
  input  logic [3:0]            cfg_r,
  input  logic [6:0]            cfg_tw,
  input  logic [IPADADDRWD:0]   cfg_upix,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ip_write,
  output logic [IPADADDRWD-1:0] ip_waddr,
  output logic                  ip_read,
  output logic [IPADADDRWD-1:0] ip_raddr,
  output logic                  wp_read,
  output logic [WPADADDRWD-1:0] wp_raddr,
  output logic                  pp_read,
  output logic [PPADADDRWD-1:0] pp_raddr,
  output logic                  fst_acc,
  output logic                  pp_write,
  output logic [PPADADDRWD-1:0] pp_waddr,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RUN, DRAIN} state_t;

  localparam int AVW = IPADADDRWD + 1;
  localparam logic [7:0]            IPAD_LIM   = 8'(IPADSIZE);
  localparam logic [12:0]           WPAD_LIM   = 13'(WPADSIZE);
  localparam logic [11:0]           PPAD_LIM   = 12'(PPADSIZE);
  localparam logic [AVW-1:0]        AVAIL_FULL = AVW'(IPADSIZE);
  localparam logic [IPADADDRWD-1:0] WPTR_LAST  = IPADADDRWD'(IPADSIZE - 1);
  localparam logic [7:0]            DRAIN_LAST = 8'(PIPE - 1);

  state_t state_reg, state_next;

  logic [3:0]            pch_reg, r_reg, c_reg, tap_reg;
  logic [4:0]            pm_reg, m_reg;
  logic [6:0]            tw_reg, x_reg;
  logic [AVW-1:0]        upix_reg, avail_reg, avail_next;
  logic [7:0]            isz_reg, roff_reg, drain_reg;
  logic [WPADADDRWD-1:0] wcnt_reg;
  logic [PPADADDRWD-1:0] pbase_reg;
  logic [IPADADDRWD-1:0] wptr_reg, base_reg, base_next, wptr_next;
  logic                  cfg_err_reg, done_reg;
  logic [PIPE-1:0]       pv_reg;
  logic [PPADADDRWD-1:0] pa_reg [PIPE];

  logic [7:0]  isz_in, ip_sum, base_sum;
  logic [12:0] wsz_in;
  logic [11:0] psz_in;
  logic        cfg_bad, issue, m_last, c_last, tap_last, pix_last, tile_last, drain_last;

  // Start-time validation works on the raw cfg inputs so a rejected start leaves nothing latched.
  assign isz_in  = 8'(cfg_pch) * 8'(cfg_r);
  assign wsz_in  = 13'(isz_in) * 13'(cfg_pm);
  assign psz_in  = 12'(cfg_pm) * 12'(cfg_tw);
  assign cfg_bad = (cfg_pch == 4'd0) || (cfg_pm == 5'd0) || (cfg_r == 4'd0) || (cfg_tw == 7'd0) ||
                   (cfg_upix == '0) || (isz_in > IPAD_LIM) || (wsz_in > WPAD_LIM) ||
                   (psz_in > PPAD_LIM) || (8'(cfg_upix) > isz_in);

  assign issue      = (state_reg == RUN) && !stall;
  assign m_last     = (m_reg == pm_reg - 5'd1);
  assign c_last     = (c_reg == pch_reg - 4'd1);
  assign tap_last   = (tap_reg == r_reg - 4'd1);
  assign pix_last   = m_last && c_last && tap_last;
  assign tile_last  = (x_reg == tw_reg - 7'd1);
  assign drain_last = (drain_reg == DRAIN_LAST);

  // Both sums stay below 2*IPADSIZE, so one conditional subtract implements the modulo.
  assign ip_sum     = 8'(base_reg) + roff_reg + 8'(c_reg);
  assign base_sum   = 8'(base_reg) + 8'(upix_reg);
  assign base_next  = (base_sum >= IPAD_LIM) ? IPADADDRWD'(base_sum - IPAD_LIM) : IPADADDRWD'(base_sum);
  assign wptr_next  = (wptr_reg == WPTR_LAST) ? '0 : wptr_reg + IPADADDRWD'(1);
  assign avail_next = avail_reg + AVW'(ip_write) - ((issue && pix_last) ? upix_reg : '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!stall) begin
      case (state_reg)
        IDLE:    if (start && !cfg_bad) state_next = WAIT;
        WAIT:    if (8'(avail_reg) >= isz_reg) state_next = RUN;
        RUN:     if (pix_last) state_next = tile_last ? DRAIN : WAIT;
        DRAIN:   if (drain_last) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state_reg != IDLE);
    in_ready = busy && !stall && (avail_reg < AVAIL_FULL);
    ip_write = in_valid && in_ready;
    ip_waddr = wptr_reg;
    ip_read  = issue;
    wp_read  = issue;
    ip_raddr = (ip_sum >= IPAD_LIM) ? IPADADDRWD'(ip_sum - IPAD_LIM) : IPADADDRWD'(ip_sum);
    wp_raddr = wcnt_reg;
    pp_raddr = pbase_reg + PPADADDRWD'(m_reg);
    fst_acc  = issue && (tap_reg == 4'd0) && (c_reg == 4'd0);
    pp_read  = issue && !((tap_reg == 4'd0) && (c_reg == 4'd0));
    pp_write = pv_reg[PIPE-1] && !stall;
    pp_waddr = pa_reg[PIPE-1];
    done     = done_reg;
    cfg_err  = cfg_err_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pch_reg <= '0; r_reg <= '0; pm_reg <= '0; tw_reg <= '0; upix_reg <= '0; isz_reg <= '0;
      m_reg <= '0; c_reg <= '0; tap_reg <= '0; roff_reg <= '0; x_reg <= '0; wcnt_reg <= '0;
      pbase_reg <= '0; base_reg <= '0; wptr_reg <= '0; avail_reg <= '0; drain_reg <= '0;
      cfg_err_reg <= 1'b0; done_reg <= 1'b0;
    end else begin
      cfg_err_reg <= !stall && (state_reg == IDLE) && start && cfg_bad;
      done_reg    <= !stall && (state_reg == DRAIN) && drain_last;
      if (!stall) begin
        if (ip_write) wptr_reg <= wptr_next;
        avail_reg <= avail_next;
        case (state_reg)
          IDLE: if (start && !cfg_bad) begin
            pch_reg <= cfg_pch; r_reg <= cfg_r; pm_reg <= cfg_pm; tw_reg <= cfg_tw;
            upix_reg <= cfg_upix; isz_reg <= isz_in;
            m_reg <= '0; c_reg <= '0; tap_reg <= '0; roff_reg <= '0;
            x_reg <= '0; wcnt_reg <= '0; pbase_reg <= '0;
          end
          RUN: begin
            // m innermost, then channel, then tap; roff tracks tap*pch without a multiplier.
            if (m_last) begin
              m_reg <= '0;
              if (c_last) begin
                c_reg <= '0;
                if (tap_last) begin
                  tap_reg <= '0; roff_reg <= '0;
                end else begin
                  tap_reg <= tap_reg + 4'd1; roff_reg <= roff_reg + 8'(pch_reg);
                end
              end else begin
                c_reg <= c_reg + 4'd1;
              end
            end else begin
              m_reg <= m_reg + 5'd1;
            end
            wcnt_reg <= pix_last ? '0 : wcnt_reg + WPADADDRWD'(1);
            if (pix_last) begin
              base_reg  <= base_next;
              pbase_reg <= pbase_reg + PPADADDRWD'(pm_reg);
              x_reg     <= x_reg + 7'd1;
              drain_reg <= '0;
            end
          end
          DRAIN: begin
            drain_reg <= drain_reg + 8'd1;
            if (drain_last) begin
              avail_reg <= '0; wptr_reg <= '0; base_reg <= '0; pbase_reg <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Write-back pipe freezes with stall so each issue yields exactly one pp_write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_reg <= '0;
      for (int i = 0; i < PIPE; i++) pa_reg[i] <= '0;
    end else if (!stall) begin
      pv_reg[0] <= issue;
      pa_reg[0] <= pp_raddr;
      for (int i = PIPE - 1; i > 0; i--) begin
        pv_reg[i] <= pv_reg[i-1];
        pa_reg[i] <= pa_reg[i-1];
      end
    end
  end

endmodule
